// File: rtl/secded_arq_pkg.sv
// secded_arq_pkg: shared FSM states, error-injection modes and width helper for the ARQ controller.
package secded_arq_pkg;
   typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_WAIT, S_DELIVER, S_FAIL} state_t;
   localparam logic [1:0] ERR_NONE   = 2'b00;
   localparam logic [1:0] ERR_SINGLE = 2'b01;
   localparam logic [1:0] ERR_DOUBLE = 2'b10;
   function automatic int cw(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/secded_arq_ctrl_if.sv
// secded_arq_ctrl_if: producer, FIFO and consumer signals of the ARQ controller.
interface secded_arq_ctrl_if import secded_arq_pkg::*; #(
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_RETRIES = 3
);
   localparam int RW = cw(MAX_RETRIES + 1);
   logic                  src_valid;
   logic [DATA_WIDTH-1:0] src_data;
   logic                  src_ready;
   logic [1:0]            inj_mode;
   logic                  fifo_wr_en;
   logic [DATA_WIDTH-1:0] fifo_data_in;
   logic                  fifo_rd_en;
   logic [1:0]            fifo_err_mode;
   logic [DATA_WIDTH-1:0] fifo_data_out;
   logic                  fifo_ack;
   logic                  fifo_nack;
   logic                  dst_valid;
   logic [DATA_WIDTH-1:0] dst_data;
   logic                  dst_ready;
   logic                  drop;
   logic                  busy;
   logic [RW-1:0]         retry_cnt;
   modport master (
      input  src_valid, src_data, inj_mode, fifo_data_out, fifo_ack, fifo_nack, dst_ready,
      output src_ready, fifo_wr_en, fifo_data_in, fifo_rd_en, fifo_err_mode, dst_valid, dst_data,
             drop, busy, retry_cnt
   );
   modport slave (
      output src_valid, src_data, inj_mode, fifo_data_out, fifo_ack, fifo_nack, dst_ready,
      input  src_ready, fifo_wr_en, fifo_data_in, fifo_rd_en, fifo_err_mode, dst_valid, dst_data,
             drop, busy, retry_cnt
   );
endinterface

// File: rtl/secded_arq_ctrl_stats.sv
// arq_stats: saturating ack/nack/drop counters; exists only when ARQ_STATS_EN is defined.
`ifdef ARQ_STATS_EN
module arq_stats (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_ack,
   input  logic        i_nack,
   input  logic        i_drop,
   output logic [15:0] o_ack,
   output logic [15:0] o_nack,
   output logic [15:0] o_drop
);
   logic [15:0] r_ack, r_nack, r_drop;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ack  <= '0;
         r_nack <= '0;
         r_drop <= '0;
      end else begin
         if (i_ack && !(&r_ack)) r_ack <= r_ack + 16'd1;
         if (i_nack && !(&r_nack)) r_nack <= r_nack + 16'd1;
         if (i_drop && !(&r_drop)) r_drop <= r_drop + 16'd1;
      end
   end
   assign o_ack  = r_ack;
   assign o_nack = r_nack;
   assign o_drop = r_drop;
endmodule
`endif

// File: rtl/secded_arq_ctrl.sv
// secded_arq_ctrl: stop-and-wait ARQ sequencer for the SECDED FIFO link.
// Optional ARQ_STATS_EN adds saturating stat_ack/stat_nack/stat_drop outputs.
module secded_arq_ctrl import secded_arq_pkg::*; #(
   parameter int DATA_WIDTH  = 8,
   parameter int MAX_RETRIES = 3,
   parameter int ACK_TIMEOUT = 4
) (
   input logic clk,
   input logic rst,
   secded_arq_ctrl_if.master bus
`ifdef ARQ_STATS_EN
   ,
   output logic [15:0] stat_ack,
   output logic [15:0] stat_nack,
   output logic [15:0] stat_drop
`endif
);
   localparam int RW = cw(MAX_RETRIES + 1);
   localparam int TW = cw(ACK_TIMEOUT + 1);
   state_t                r_state, w_next;
   logic [DATA_WIDTH-1:0] r_hold, r_dst;
   logic [1:0]            r_mode;
   logic [RW-1:0]         r_retry;
   logic [TW-1:0]         r_to;
   logic                  r_src_ready;
   logic                  w_ack, w_bad, w_can_retry, w_accept;
   assign w_accept    = r_state == S_IDLE && bus.src_valid;
   assign w_ack       = r_state == S_WAIT && !bus.fifo_nack && bus.fifo_ack;
   // nack beats ack; a timeout only counts when no ack arrived that cycle
   assign w_bad       = r_state == S_WAIT && (bus.fifo_nack || (!bus.fifo_ack && r_to == TW'(ACK_TIMEOUT - 1)));
   assign w_can_retry = r_retry < RW'(MAX_RETRIES);
   always_comb begin
      w_next = S_IDLE;
      unique case (r_state)
         S_IDLE:    w_next = bus.src_valid ? S_WRITE : S_IDLE;
         S_WRITE:   w_next = S_READ;
         S_READ:    w_next = S_WAIT;
         S_WAIT:    w_next = w_ack ? S_DELIVER : w_bad ? (w_can_retry ? S_WRITE : S_FAIL) : S_WAIT;
         S_DELIVER: w_next = bus.dst_ready ? S_IDLE : S_DELIVER;
         default:   w_next = S_IDLE;
      endcase
   end
   // src_ready is registered so it stays low throughout reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_src_ready <= 1'b0;
         r_hold      <= '0;
         r_dst       <= '0;
         r_mode      <= ERR_NONE;
         r_retry     <= '0;
         r_to        <= '0;
      end else begin
         r_state     <= w_next;
         r_src_ready <= w_next == S_IDLE;
         if (w_accept) begin
            r_hold  <= bus.src_data;
            r_mode  <= bus.inj_mode;
            r_retry <= '0;
         end else if (w_bad && w_can_retry) begin
            r_retry <= r_retry + 1'b1;
            r_mode  <= ERR_NONE;
         end else if (w_ack || w_bad) begin
            r_mode  <= ERR_NONE;
         end
         if (w_ack) r_dst <= bus.fifo_data_out;
         r_to <= (r_state == S_READ) ? '0 :
                 (r_state == S_WAIT && r_to != TW'(ACK_TIMEOUT)) ? r_to + 1'b1 : r_to;
      end
   end
   assign bus.src_ready     = r_src_ready;
   assign bus.fifo_wr_en    = r_state == S_WRITE;
   assign bus.fifo_data_in  = r_hold;
   assign bus.fifo_rd_en    = r_state == S_READ;
   assign bus.fifo_err_mode = r_mode;
   assign bus.dst_valid     = r_state == S_DELIVER;
   assign bus.dst_data      = r_dst;
   assign bus.drop          = r_state == S_FAIL;
   assign bus.busy          = r_state != S_IDLE;
   assign bus.retry_cnt     = r_retry;
`ifdef ARQ_STATS_EN
   arq_stats u_stats (
      .clk    (clk),
      .rst    (rst),
      .i_ack  (w_ack),
      .i_nack (w_bad),
      .i_drop (r_state == S_FAIL),
      .o_ack  (stat_ack),
      .o_nack (stat_nack),
      .o_drop (stat_drop)
   );
`endif
endmodule

// File: tb/tb_secded_arq_ctrl.sv
// tb_secded_arq_ctrl: directed bench with a behavioural SECDED FIFO stub (ARQ_STATS_EN optional).
`timescale 1ns/1ps
module tb_secded_arq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   secded_arq_ctrl_if #(.DATA_WIDTH(8), .MAX_RETRIES(3)) bus ();
`ifdef ARQ_STATS_EN
   logic [15:0] stat_ack, stat_nack, stat_drop;
`endif
   secded_arq_ctrl #(.DATA_WIDTH(8), .MAX_RETRIES(3), .ACK_TIMEOUT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ARQ_STATS_EN
      ,
      .stat_ack  (stat_ack),
      .stat_nack (stat_nack),
      .stat_drop (stat_drop)
`endif
   );
   always #5 clk = ~clk;
   // FIFO stub: 0 = single errors corrected / double errors nacked, 1 = always nack, 2 = silent
   int         stub_mode = 0;
   int         wr_cnt = 0;
   int         drop_seen = 0;
   logic [1:0] wr_modes [0:255];
   logic [7:0] st_data = '0;
   logic [1:0] st_mode = '0;
   logic       ack_r = 1'b0, nack_r = 1'b0;
   logic [7:0] dout_r = '0;
   assign bus.fifo_ack      = ack_r;
   assign bus.fifo_nack     = nack_r;
   assign bus.fifo_data_out = dout_r;
   always @(posedge clk) begin
      ack_r  <= 1'b0;
      nack_r <= 1'b0;
      if (bus.fifo_wr_en) begin
         st_data            <= bus.fifo_data_in;
         st_mode            <= bus.fifo_err_mode;
         wr_modes[wr_cnt]   <= bus.fifo_err_mode;
         wr_cnt             <= wr_cnt + 1;
      end
      if (bus.fifo_rd_en) begin
         dout_r <= st_data;
         if (stub_mode == 1 || (stub_mode == 0 && st_mode == 2'b10)) nack_r <= 1'b1;
         else if (stub_mode == 0) ack_r <= 1'b1;
      end
   end
   always @(negedge clk) if (bus.drop) drop_seen <= drop_seen + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // offer a word and check WRITE at +1 and READ at +2; returns at the first WAIT negedge
   task automatic send(input logic [7:0] d, input logic [1:0] m);
      int n = 0;
      while (!bus.src_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("src_ready_before_send", 32'(bus.src_ready), 1);
      bus.src_valid = 1'b1;
      bus.src_data  = d;
      bus.inj_mode  = m;
      @(negedge clk);
      bus.src_valid = 1'b0;
      chk("wr_en_at_plus1", 32'(bus.fifo_wr_en), 1);
      chk("err_mode_first_attempt", 32'(bus.fifo_err_mode), 32'(m));
      chk("fifo_data_in", 32'(bus.fifo_data_in), 32'(d));
      @(negedge clk);
      chk("rd_en_at_plus2", 32'(bus.fifo_rd_en), 1);
      @(negedge clk);
   endtask
   task automatic wait_dv(output int n);
      n = 0;
      while (!bus.dst_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("dst_valid_arrives", 32'(bus.dst_valid), 1);
   endtask
   typedef struct {
      logic [7:0] d;
      logic [1:0] m;
      logic [7:0] exp_data;
      int         exp_retry;
      int         exp_writes;
      logic [1:0] exp_last_mode;
      int         exp_lat;
   } vec_t;
   vec_t vecs [5];
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      int n, w0, d0;
      logic [15:0] s_nack0, s_drop0;
      vecs[0] = '{8'hA5, 2'b00, 8'hA5, 0, 1, 2'b00, 1};
      vecs[1] = '{8'h3C, 2'b01, 8'h3C, 0, 1, 2'b01, 1};
      vecs[2] = '{8'h5A, 2'b10, 8'h5A, 1, 2, 2'b00, 4};
      vecs[3] = '{8'hFF, 2'b10, 8'hFF, 1, 2, 2'b00, 4};
      vecs[4] = '{8'h00, 2'b01, 8'h00, 0, 1, 2'b01, 1};
      bus.src_valid = 1'b0;
      bus.src_data  = '0;
      bus.inj_mode  = '0;
      bus.dst_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rst_src_ready", 32'(bus.src_ready), 0);
      chk("rst_busy", 32'(bus.busy), 0);
      chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
      chk("rst_dst_valid", 32'(bus.dst_valid), 0);
      chk("rst_drop", 32'(bus.drop), 0);
      chk("rst_err_mode", 32'(bus.fifo_err_mode), 0);
      rst = 1'b0;
      @(negedge clk);
      chk("src_ready_after_rst", 32'(bus.src_ready), 1);
      for (int i = 0; i < 5; i++) begin
         w0 = wr_cnt;
         d0 = drop_seen;
         send(vecs[i].d, vecs[i].m);
         wait_dv(n);
         chk($sformatf("v%0d_latency", i), 32'(n), 32'(vecs[i].exp_lat));
         chk($sformatf("v%0d_dst_data", i), 32'(bus.dst_data), 32'(vecs[i].exp_data));
         chk($sformatf("v%0d_retry_cnt", i), 32'(bus.retry_cnt), 32'(vecs[i].exp_retry));
         chk($sformatf("v%0d_writes", i), 32'(wr_cnt - w0), 32'(vecs[i].exp_writes));
         chk($sformatf("v%0d_last_wr_mode", i), 32'(wr_modes[wr_cnt - 1]), 32'(vecs[i].exp_last_mode));
         chk($sformatf("v%0d_err_mode_deliver", i), 32'(bus.fifo_err_mode), 0);
         chk($sformatf("v%0d_no_drop", i), 32'(drop_seen - d0), 0);
         bus.dst_ready = 1'b1;
         @(negedge clk);
         bus.dst_ready = 1'b0;
         chk($sformatf("v%0d_dv_clears", i), 32'(bus.dst_valid), 0);
         chk($sformatf("v%0d_idle_ready", i), 32'(bus.src_ready), 1);
      end
      // retries exhausted
`ifdef ARQ_STATS_EN
      s_nack0 = stat_nack;
      s_drop0 = stat_drop;
`else
      s_nack0 = '0;
      s_drop0 = '0;
`endif
      stub_mode = 1;
      w0 = wr_cnt;
      d0 = drop_seen;
      send(8'h77, 2'b01);
      n = 0;
      while (!bus.drop && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("exh_drop_high", 32'(bus.drop), 1);
      chk("exh_retry_cnt", 32'(bus.retry_cnt), 3);
      chk("exh_writes", 32'(wr_cnt - w0), 4);
      chk("exh_err_mode_fail", 32'(bus.fifo_err_mode), 0);
      @(negedge clk);
      chk("exh_drop_one_cycle", 32'(bus.drop), 0);
      chk("exh_back_idle", 32'(bus.busy), 0);
      chk("exh_src_ready", 32'(bus.src_ready), 1);
      chk("exh_drop_count", 32'(drop_seen - d0), 1);
`ifdef ARQ_STATS_EN
      chk("stat_nack_delta", 32'(stat_nack - s_nack0), 4);
      chk("stat_drop_delta", 32'(stat_drop - s_drop0), 1);
`endif
      // timeout then acked retransmission
      stub_mode = 2;
      send(8'h96, 2'b00);
      n = 1;
      while (!bus.fifo_wr_en && n < 20) begin
         @(negedge clk);
         if (!bus.fifo_wr_en) n++;
      end
      chk("timeout_wait_cycles", 32'(n), 4);
      chk("timeout_retry_cnt", 32'(bus.retry_cnt), 1);
      chk("timeout_err_mode", 32'(bus.fifo_err_mode), 0);
      stub_mode = 0;
      wait_dv(n);
      chk("timeout_dst_data", 32'(bus.dst_data), 32'h96);
      bus.dst_ready = 1'b1;
      @(negedge clk);
      bus.dst_ready = 1'b0;
      // reset during WAIT
      stub_mode = 2;
      d0 = drop_seen;
      send(8'hE1, 2'b10);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_busy", 32'(bus.busy), 0);
      chk("midrst_src_ready", 32'(bus.src_ready), 0);
      chk("midrst_err_mode", 32'(bus.fifo_err_mode), 0);
      chk("midrst_data_in", 32'(bus.fifo_data_in), 0);
      chk("midrst_dst_data", 32'(bus.dst_data), 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_ready_after", 32'(bus.src_ready), 1);
      chk("midrst_retry_cnt", 32'(bus.retry_cnt), 0);
      chk("midrst_no_drop", 32'(drop_seen - d0), 0);
      // backpressure in DELIVER with a competing src_valid
      stub_mode = 0;
      send(8'hC3, 2'b00);
      wait_dv(n);
      w0 = wr_cnt;
      bus.src_valid = 1'b1;
      bus.src_data  = 8'h11;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp%0d_dst_valid", k), 32'(bus.dst_valid), 1);
         chk($sformatf("bp%0d_dst_data", k), 32'(bus.dst_data), 32'hC3);
         chk($sformatf("bp%0d_src_ready", k), 32'(bus.src_ready), 0);
      end
      bus.src_valid = 1'b0;
      bus.dst_ready = 1'b1;
      @(negedge clk);
      bus.dst_ready = 1'b0;
      chk("bp_no_write", 32'(wr_cnt - w0), 0);
      chk("bp_release_idle", 32'(bus.busy), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/secded_arq_ctrl.md
# secded_arq_ctrl

Stop-and-wait ARQ controller that sequences the SECDED FIFO link (`secdec_fifo_arq`) on behalf of a single upstream producer. It:
- accepts one word at a time and writes it into the FIFO;
- issues the read and waits for the registered ack/nack;
- on nack or timeout, retransmits with error injection forced clean, up to a retry limit;
- delivers the acked word downstream or reports a drop.

## Interface
- `DATA_WIDTH`, 8, payload width (matches FIFO `DATA_WIDTH`)
- `MAX_RETRIES`, 3, retransmissions allowed after the first attempt (0 = none)
- `ACK_TIMEOUT`, 4, WAIT cycles without ack/nack before the attempt counts as nack (≥1)

Ports:
- `clk`  in  1  clock; all logic is rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `src_valid`  in  1  upstream word offered
- `src_data`  in  DATA_WIDTH  upstream word
- `src_ready`  out  1  controller accepts a word
- `inj_mode`  in  2  error-injection mode for the first attempt
- `fifo_wr_en`  out  1  FIFO write strobe
- `fifo_data_in`  out  DATA_WIDTH  FIFO write data
- `fifo_rd_en`  out  1  FIFO read strobe
- `fifo_err_mode`  out  2  FIFO error-injection mode
- `fifo_data_out`  in  DATA_WIDTH  FIFO read data
- `fifo_ack`  in  1  registered ack from FIFO
- `fifo_nack`  in  1  registered nack from FIFO
- `dst_valid`  out  1  delivered word valid
- `dst_data`  out  DATA_WIDTH  delivered word
- `dst_ready`  in  1  downstream accepts
- `drop`  out  1  one-cycle pulse: word abandoned after retries exhausted
- `busy`  out  1  state ≠ IDLE
- `retry_cnt`  out  clog2(MAX_RETRIES+1)  retries used on the current word

## Operation
All outputs are registered or decoded from state (Moore); no combinational paths from input to output.

FSM states and transitions:
- **IDLE**
  - `src_ready`=1.
  - On `src_valid`: latch `src_data` into the hold register, latch `inj_mode` into the mode register, clear `retry_cnt` → WRITE.
- **WRITE**
  - `fifo_wr_en`=1 for exactly one cycle; `fifo_data_in`=hold register → READ.
- **READ**
  - `fifo_rd_en`=1 for exactly one cycle → WAIT; clear the timeout counter.
- **WAIT**
  - Each cycle, sample `fifo_nack` and `fifo_ack`. nack has priority over ack when both are high.
  - ack: capture `fifo_data_out` into `dst_data` → DELIVER.
  - nack, or timeout counter reaching ACK_TIMEOUT:
    - if `retry_cnt` < MAX_RETRIES: increment `retry_cnt`, set mode register to 2'b00 → WRITE;
    - otherwise → FAIL.
- **DELIVER**
  - `dst_valid`=1; `dst_data` is stable while held.
  - On `dst_ready` → IDLE.
- **FAIL**
  - `drop`=1 for one cycle → IDLE.

`fifo_err_mode` always equals the mode register, and holds for the full attempt (WRITE through WAIT). It is 00 in IDLE, DELIVER and FAIL.

Boundary behaviour:
- ack/nack arriving outside WAIT: ignored.
- `dst_ready` outside DELIVER: ignored.
- `src_valid` outside IDLE: not accepted. The producer holds the word.
- MAX_RETRIES=0: the first nack goes straight to FAIL.
- Timeout counter width is clog2(ACK_TIMEOUT+1) and it saturates.
- `rst` asserted mid-operation: immediately → IDLE, hold/mode/counters cleared, the word is discarded, and no `drop` is emitted.

## Timing
- Reset values: `src_ready`=0 while `rst` is high, and 1 in the first cycle after release. All other outputs are 0.
- From the accept edge:
  - `fifo_wr_en` high in cycle +1;
  - `fifo_rd_en` high in cycle +2;
  - WAIT starts in cycle +3.
- `dst_valid` rises the cycle after ack is sampled in WAIT.
- Retransmit: `fifo_wr_en` rises the cycle after nack/timeout is sampled.
- Minimum per-word occupancy: 5 cycles (IDLE, WRITE, READ, one WAIT, DELIVER).

## Configuration
- `ARQ_STATS_EN` defined: adds outputs `stat_ack`, `stat_nack` and `stat_drop`, each 16 bits.
  - Saturating counters.
  - `stat_ack` increments on each WAIT→DELIVER.
  - `stat_nack` increments on each nack or timeout.
  - `stat_drop` increments on each FAIL.
  - Cleared by `rst`.
- `ARQ_STATS_EN` undefined: these ports and counters do not exist; all other behaviour is identical.

## Structure
- Package `secded_arq_pkg` contains:
  - the state enum;
  - err-mode constants `ERR_NONE`=2'b00, `ERR_SINGLE`=2'b01, `ERR_DOUBLE`=2'b10.
- Sub-module `arq_stats` holds the three saturating counters. It is instantiated only under `ARQ_STATS_EN`.

## Test plan
Run against a real `secdec_fifo_arq` (DATA_WIDTH=8, FIFO_DEPTH=4) unless stated otherwise.
- **Clean delivery:** `src_data`=8'hA5, `inj_mode`=00 → one write, `dst_data`=8'hA5, `retry_cnt`=0, no `drop`.
- **Single-bit injection:** 8'h3C, `inj_mode`=01 → corrected, acked on the first attempt, `dst_data`=8'h3C, `retry_cnt`=0.
- **Double-bit injection:** 8'h5A, `inj_mode`=10 → nack, second write with `fifo_err_mode`=00, `dst_data`=8'h5A, `retry_cnt`=1.
- **Retries exhausted:** stub FIFO always nacks, MAX_RETRIES=3 → 4 writes, then a one-cycle `drop`, then back to IDLE; with `ARQ_STATS_EN`, `stat_nack`=4 and `stat_drop`=1.
- **Timeout:** stub FIFO never responds, ACK_TIMEOUT=4 → retransmit after 4 WAIT cycles.
- **Reset and backpressure:** assert `rst` during WAIT → all outputs 0 and no `drop`. Hold `dst_ready`=0 for 3 cycles in DELIVER → `dst_valid`/`dst_data` stay stable and `src_ready` stays 0.
